// File: rtl/des_pkg.sv
// Shared DES key-schedule constants and helpers.
// Tables use DES bit numbering (bit 1 = MSB). Vectors are packed [N-1:0],
// so DES bit p of an N-bit vector lives at index N-p.
package des_pkg;

  localparam int unsigned PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // Rotation amount for round r is at index r-1.
  localparam int unsigned SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // PC-1: 64-bit key to {C0, D0}; parity bits are simply never selected.
  function automatic logic [55:0] pc1(input logic [63:0] key);
    logic [55:0] cd;
    cd = '0;
    for (int unsigned i = 0; i < 56; i++) begin
      cd[6'(55 - i)] = key[6'(64 - PC1[i])];
    end
    return cd;
  endfunction

  // Rotate one 28-bit half by 1 or 2 positions.
  function automatic logic [27:0] rot28(input logic [27:0] x, input logic left, input logic two);
    logic [27:0] r;
    if (left) r = two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    else      r = two ? {x[1:0], x[27:2]}   : {x[0], x[27:1]};
    return r;
  endfunction

endpackage

// File: rtl/des_pc2.sv
// PC-2 permutation: 56-bit {C, D} to a 48-bit round key.
// Ports: cd (input, C in [55:28], D in [27:0]), subkey (output, 48 bits).
module des_pc2
  import des_pkg::*;
(
  input  logic [55:0] cd,
  output logic [47:0] subkey
);

  always_comb begin
    subkey = '0;
    for (int unsigned i = 0; i < 48; i++) begin
      subkey[6'(47 - i)] = cd[6'(56 - PC2[i])];
    end
  end

endmodule

// File: rtl/des_key_schedule_seq.sv
// Sequential DES round-key scheduler: one 48-bit subkey per valid/ready
// handshake, K16..K1 (DECRYPT=1) or K1..K16 (DECRYPT=0).
// Ports: clk, reset (async, active high), key_64 [1:64], start (sampled in
// IDLE), subkey [1:48] / subkey_valid / subkey_ready handshake, round_num
// (16 encoded as 0), busy (start accepted .. last handshake), done (1-cycle
// pulse after the final handshake).
module des_key_schedule_seq
  import des_pkg::*;
#(
  parameter bit          DECRYPT = 1'b1,
  parameter int unsigned ROUNDS  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:64] key_64,
  input  logic        start,
  output logic [1:48] subkey,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [3:0]  round_num,
  output logic        busy,
  output logic        done
);

  localparam logic [3:0] FIRST_ROUND = DECRYPT ? 4'(ROUNDS) : 4'd1;
  localparam logic [3:0] LAST_ROUND  = DECRYPT ? 4'd1 : 4'(ROUNDS);

  state_e      state_q, state_d;
  logic [27:0] c_q, d_q;
  logic [3:0]  round_q;
  logic        load, advance;
  logic [55:0] cd0;
  logic [3:0]  shift_idx;
  logic        shift_two;
  logic [47:0] pc2_out;

  assign cd0 = pc1(key_64);

  // Decrypt undoes s(r) going r -> r-1; encrypt applies s(r+1) going r -> r+1.
  // With 16 encoded as 0, both reduce to a plain 4-bit index.
  assign shift_idx = DECRYPT ? round_q - 4'd1 : round_q;
  assign shift_two = (SHIFTS[shift_idx] == 2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    subkey_valid = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    load         = 1'b0;
    advance      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        subkey_valid = 1'b1;
        busy         = 1'b1;
        if (subkey_ready) begin
          advance = 1'b1;
          if (round_q == LAST_ROUND) state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Decrypt loads C0/D0 directly: after 28 total shifts C16/D16 equal C0/D0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
    end else if (load) begin
      if (DECRYPT) begin
        c_q <= cd0[55:28];
        d_q <= cd0[27:0];
      end else begin
        c_q <= rot28(cd0[55:28], 1'b1, 1'b0);
        d_q <= rot28(cd0[27:0], 1'b1, 1'b0);
      end
      round_q <= FIRST_ROUND;
    end else if (advance && round_q != LAST_ROUND) begin
      c_q     <= rot28(c_q, !DECRYPT, shift_two);
      d_q     <= rot28(d_q, !DECRYPT, shift_two);
      round_q <= DECRYPT ? round_q - 4'd1 : round_q + 4'd1;
    end
  end

  des_pc2 u_pc2 (
    .cd     ({c_q, d_q}),
    .subkey (pc2_out)
  );

  assign subkey    = pc2_out;
  assign round_num = round_q;

endmodule

// File: tb/tb_des_key_schedule_seq.sv
// Scoreboard bench: a decrypt and an encrypt instance share stimulus; expected
// {round, key} pairs are queued per instance and popped by a negedge monitor.
module tb_des_key_schedule_seq;

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [63:0] PAR   = 64'h0101010101010101;
  localparam logic [47:0] K1    = 48'h1B02EFFC7072;
  localparam logic [47:0] K16   = 48'hCB3D8B0E17F5;

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SH_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic        clk = 1'b0;
  logic        reset, start, ready;
  logic [63:0] key;
  logic [47:0] sk [2];
  logic        valid [2];
  logic        busy [2];
  logic        done [2];
  logic [3:0]  rn [2];

  int          tests = 0;
  int          fails = 0;
  logic [51:0] q [2][$];
  int          hs_cnt [2];
  bit          hold [2];
  bit          pend [2];
  logic [51:0] held [2];

  always #5 clk = ~clk;

  des_key_schedule_seq #(.DECRYPT(1'b1), .ROUNDS(16)) dut_dec (
    .clk(clk), .reset(reset), .key_64(key), .start(start),
    .subkey(sk[0]), .subkey_valid(valid[0]), .subkey_ready(ready),
    .round_num(rn[0]), .busy(busy[0]), .done(done[0])
  );

  des_key_schedule_seq #(.DECRYPT(1'b0), .ROUNDS(16)) dut_enc (
    .clk(clk), .reset(reset), .key_64(key), .start(start),
    .subkey(sk[1]), .subkey_valid(valid[1]), .subkey_ready(ready),
    .round_num(rn[1]), .busy(busy[1]), .done(done[1])
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Kn from first principles: Cn/Dn are C0/D0 rotated left by the cumulative shift.
  function automatic logic [47:0] model_key(input logic [63:0] k, input int n);
    bit c0 [28];
    bit d0 [28];
    bit cd [56];
    int tot;
    logic [47:0] r;
    for (int j = 0; j < 28; j++) begin
      c0[j] = k[64 - PC1_T[j]];
      d0[j] = k[64 - PC1_T[j + 28]];
    end
    tot = 0;
    for (int s = 0; s < n; s++) tot += SH_T[s];
    for (int j = 0; j < 28; j++) begin
      cd[j]      = c0[(j + tot) % 28];
      cd[j + 28] = d0[(j + tot) % 28];
    end
    for (int i = 0; i < 48; i++) r[47 - i] = cd[PC2_T[i] - 1];
    return r;
  endfunction

  task automatic push_exp(input logic [63:0] mkey);
    for (int n = 1; n <= 16; n++) begin
      q[0].push_back({4'(17 - n), model_key(mkey, 17 - n)});
      q[1].push_back({4'(n), model_key(mkey, n)});
    end
  endtask

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (reset) begin
        q[u].delete();
        hs_cnt[u] = 0;
        hold[u]   = 0;
        pend[u]   = 0;
      end else begin
        if (hold[u]) begin
          chk($sformatf("hold_subkey_%0d", u), 64'(sk[u]), 64'(held[u][47:0]));
          chk($sformatf("hold_round_%0d", u), 64'(rn[u]), 64'(held[u][51:48]));
        end
        if (pend[u]) begin
          chk($sformatf("done_after_last_hs_%0d", u), 64'(done[u]), 64'd1);
          pend[u] = 0;
        end
        if (done[u]) begin
          chk($sformatf("hs_before_done_%0d", u), 64'(hs_cnt[u]), 64'd16);
          hs_cnt[u] = 0;
        end
        if (valid[u] && ready) begin
          if (q[u].size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_key_%0d: got 0x%0h, expected no transfer", u, sk[u]);
          end else begin
            logic [51:0] e;
            e = q[u].pop_front();
            chk($sformatf("subkey_%0d_r%0d", u, e[51:48]), 64'(sk[u]), 64'(e[47:0]));
            chk($sformatf("round_num_%0d", u), 64'(rn[u]), 64'(e[51:48]));
          end
          hs_cnt[u]++;
          if (hs_cnt[u] == 16) pend[u] = 1;
        end
        hold[u] = valid[u] && !ready;
        held[u] = {rn[u], sk[u]};
      end
    end
  end

  task automatic wait_done(input int unsigned duty, output int unsigned cyc);
    bit got;
    got = 0;
    cyc = 0;
    while (!got && cyc < 500) begin
      ready = (duty >= 100) ? 1'b1 : ($urandom_range(0, 99) < duty);
      @(negedge clk);
      cyc++;
      if (done[0]) got = 1;
      else begin
        chk("busy_in_run", 64'(busy[0]), 64'd1);
        @(posedge clk);
        #1;
      end
    end
    chk("done_seen", 64'(got), 64'd1);
    chk("done_enc_together", 64'(done[1]), 64'd1);
    chk("busy_low_at_done", 64'(busy[0]), 64'd0);
    chk("valid_low_at_done", 64'(valid[0]), 64'd0);
  endtask

  task automatic run_one(input logic [63:0] dkey, input logic [63:0] mkey,
                         input int unsigned duty, output int unsigned cyc);
    push_exp(mkey);
    @(posedge clk); #1;
    key   = dkey;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(duty, cyc);
  endtask

  task automatic chk_zero(input string tag);
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("%s_valid_%0d", tag, u), 64'(valid[u]), 64'd0);
      chk($sformatf("%s_busy_%0d", tag, u), 64'(busy[u]), 64'd0);
      chk($sformatf("%s_done_%0d", tag, u), 64'(done[u]), 64'd0);
      chk($sformatf("%s_subkey_%0d", tag, u), 64'(sk[u]), 64'd0);
      chk($sformatf("%s_round_%0d", tag, u), 64'(rn[u]), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000 ns");
    $fatal(1);
  end

  initial begin
    int unsigned cyc;
    int          n;
    reset = 1'b1;
    start = 1'b0;
    ready = 1'b0;
    key   = '0;
    #3;
    chk_zero("reset");
    chk("model_k1", 64'(model_key(KEY_A, 1)), 64'(K1));
    chk("model_k16", 64'(model_key(KEY_A, 16)), 64'(K16));
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Ready held high: back-to-back keys, 17 cycles start to done.
    run_one(KEY_A, KEY_A, 100, cyc);
    chk("start_to_done_cycles", 64'(cyc), 64'd17);

    // Random 30% ready.
    run_one(KEY_A, KEY_A, 30, cyc);

    // start held high, key changed mid-run; reload only after done.
    push_exp(KEY_A);
    push_exp(64'h0);
    @(posedge clk); #1;
    key   = KEY_A;
    start = 1'b1;
    ready = 1'b1;
    repeat (8) @(posedge clk);
    #1 key = '0;
    wait_done(100, cyc);
    @(posedge clk);
    @(negedge clk);
    chk("idle_valid_after_done", 64'(valid[0]), 64'd0);
    chk("idle_busy_after_done", 64'(busy[0]), 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(100, cyc);
    chk("second_load_cycles", 64'(cyc), 64'd17);

    // Async reset during the 7th presented key.
    push_exp(KEY_A);
    @(posedge clk); #1;
    key   = KEY_A;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ready = 1'b1;
    n = 0;
    while (hs_cnt[0] != 7 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    chk("reached_hs7", 64'(hs_cnt[0]), 64'd7);
    #1 reset = 1'b1;
    #1 chk_zero("async_reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    run_one(KEY_A, KEY_A, 100, cyc);
    chk("after_reset_cycles", 64'(cyc), 64'd17);

    // Parity bits do not matter.
    run_one(KEY_A ^ PAR, KEY_A, 100, cyc);

    repeat (3) @(posedge clk);
    chk("queue_drained_dec", 64'(q[0].size()), 64'd0);
    chk("queue_drained_enc", 64'(q[1].size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/des_key_schedule_seq.md
Name: des_key_schedule_seq

Overview:
Sequential DES/3DES round-key scheduler. It produces one 48-bit subkey per handshake, so the cipher round datapath can consume keys iteratively instead of needing all 16 keys at once. Its default order is decryption (K16 down to K1, right rotations). It is the reverse-direction counterpart of the combinational encryption key generator. In a 3DES core, one instance serves each E/D/E stage and runs in the mode that stage needs.

Parameters:
DECRYPT, 1, 1 = emit K16..K1 using right rotations; 0 = emit K1..K16 using left rotations
ROUNDS, 16, number of subkeys per key load (fixed at 16 for DES; not otherwise legal)

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high reset
key_64  input  [1:64]  DES key, DES bit numbering (bit 1 = MSB); parity bits 8,16,..,64 ignored
start  input  1  load request; sampled only in IDLE
subkey  output  [1:48]  current round key, PC-2 output
subkey_valid  output  1  subkey holds a valid key
subkey_ready  input  1  consumer accepts subkey when high together with subkey_valid
round_num  output  [3:0]  DES round of the presented subkey (1..16, encoded 16 as 4'd0)
busy  output  1  high from start acceptance until the last handshake
done  output  1  one-cycle pulse the cycle after the final handshake

Behaviour:
- Reset (async assert, sync deassert by the system): state IDLE; C, D, subkey, round counter cleared to 0; subkey_valid, busy and done all 0.
- States:
  - IDLE: on start=1, apply PC-1 to key_64 to get C0 and D0 (28 bits each), then go to RUN. key_64 is sampled only here; later changes are ignored.
    - DECRYPT=1: load C=C0, D=D0. This equals C16/D16 because the total shift over 16 rounds is 28. round=16.
    - DECRYPT=0: load C=ROL(C0,1), D=ROL(D0,1). round=1.
  - RUN: subkey_valid=1, busy=1; subkey=PC-2(C,D), taken combinationally from the C/D registers.
    - Latency: first subkey is valid the cycle after start is accepted.
  - DONE: done=1 for exactly one cycle, busy=0, subkey_valid=0; then go to IDLE.
- Handshake:
  - Only valid&ready advances the schedule.
  - While valid&!ready, subkey and round_num are held stable; this is a bench assertion.
  - Back-to-back transfers, one key per cycle, are sustained when ready is held high. A full schedule takes 16 handshakes, so the minimum is 17 cycles from start to done.
- Shift schedule: s(r)=1 for r in {1,2,9,16}, otherwise 2.
  - Decrypt, on handshake at round r>1: C,D <= ROR(C,s(r)), ROR(D,s(r)); round <= r-1.
  - Encrypt, on handshake at round r<16: C,D <= ROL(C,s(r+1)), ROL(D,s(r+1)); round <= r+1.
  - Rotations are modulo 28 within each half; C and D never mix.
- Termination: a handshake on the last round (round 1 when decrypting, round 16 when encrypting) moves the FSM to DONE. C and D then hold their values.
- start while not IDLE is ignored, including in the DONE cycle. A new start is accepted in the cycle after done.
- subkey_ready while subkey_valid=0 has no effect.
- Reset asserted mid-schedule aborts immediately to the reset state. No done pulse is produced and no partial state survives.
- round_num is 4 bits; value 16 is encoded as 4'd0, and the consumer decodes it.

Decomposition:
- Package des_pkg:
  - PC1 table (56 entries) and PC2 table (48 entries) as constant index arrays in DES numbering.
  - Shift schedule constant (16 entries).
  - FSM state enum: IDLE, RUN, DONE.
- Sub-module des_pc2: combinational permutation, 56 bits to 48 bits. It is shared with the existing generator.
- PC-1 and the rotations stay inline in this block.

Test Plan:
- Decrypt default: key_64=64'h133457799BBCDFF1, start pulse, ready held high.
  - Cycle 1 after start: round_num=0 (round 16) and subkey=110010_110011_110110_001011_000011_100001_011111_110101.
  - 16th handshake: round_num=1 and subkey=000110_110000_001011_101111_111111_000111_000001_110010.
  - done pulses exactly once, in the following cycle.
- DECRYPT=0 with the same key: first subkey equals the K1 value above and the last equals the K16 value above. All 16 keys match the combinational generator's outputs, compared one by one.
- Backpressure: drive ready with a random 30% duty. subkey and round_num stay stable whenever valid&!ready; the key sequence is identical to the ready-high run; done comes after exactly 16 handshakes.
- start held high through the whole run, with key_64 changed to 64'h0 mid-run: the sequence is unaffected. The second load is accepted only the cycle after done and produces the all-zero schedule (all subkeys 48'h0).
- Async reset asserted at handshake 7, between clock edges: subkey_valid, busy, done, subkey and round_num go to 0 immediately without waiting for a clock edge. A fresh start then reproduces the scenario-1 sequence from K16.
- Parity independence: key 64'h133457799BBCDFF1 XOR 64'h0101010101010101 produces a schedule identical to scenario 1.
